mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 56 +++++
 rtl/mem_data_align.sv | 55 +++++
 rtl/mem_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: operation bit indices,
// bus widths, FSM state encodings and the alignment check.
package mem_ctrl_pkg;

  localparam int XLEN      = 64;
  localparam int BUS_BYTES = 8;
  localparam int LOAD_W    = 7;
  localparam int SAVE_W    = 4;
  localparam int REG_W     = 5;

  // Bit positions inside the one-hot load_info vector
  localparam int LOAD_LB  = 0;
  localparam int LOAD_LH  = 1;
  localparam int LOAD_LW  = 2;
  localparam int LOAD_LD  = 3;
  localparam int LOAD_LBU = 4;
  localparam int LOAD_LHU = 5;
  localparam int LOAD_LWU = 6;

  // Bit positions inside the one-hot save_info vector
  localparam int SAVE_SB = 0;
  localparam int SAVE_SH = 1;
  localparam int SAVE_SW = 2;
  localparam int SAVE_SD = 3;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_REQ  = 2'd1,
    MEM_ST_WAIT = 2'd2,
    MEM_ST_DONE = 2'd3
  } mem_state_t;

  // An access is misaligned when its size does not divide the byte offset
  // inside the 8-byte bus word.
  function automatic logic is_misaligned(input logic              is_load,
                                         input logic [LOAD_W-1:0] load_info,
                                         input logic [SAVE_W-1:0] save_info,
                                         input logic [2:0]        addr_lo);
    logic half;
    logic word;
    logic dbl;
    if (is_load) begin
      half = load_info[LOAD_LH] | load_info[LOAD_LHU];
      word = load_info[LOAD_LW] | load_info[LOAD_LWU];
      dbl  = load_info[LOAD_LD];
    end else begin
      half = save_info[SAVE_SH];
      word = save_info[SAVE_SW];
      dbl  = save_info[SAVE_SD];
    end
    return (half & addr_lo[0]) |
           (word & (addr_lo[1:0] != 2'b00)) |
           (dbl  & (addr_lo != 3'b000));
  endfunction

endpackage

// File: rtl/mem_data_align.sv
// Purely combinational byte-lane steering: places store data and byte
// enables on the 8-byte bus, and pulls/extends load data from it.
module mem_data_align
  import mem_ctrl_pkg::*;
(
  input  logic [SAVE_W-1:0]    save_info,
  input  logic [LOAD_W-1:0]    load_info,
  input  logic [2:0]           addr_lo,
  input  logic [XLEN-1:0]      wdata,
  input  logic [XLEN-1:0]      rdata,
  output logic [XLEN-1:0]      lane_wdata,
  output logic [BUS_BYTES-1:0] lane_wmask,
  output logic [XLEN-1:0]      load_data
);

  logic [5:0]  bit_off;
  logic [31:0] lane;

  assign bit_off = {addr_lo, 3'b000};
  assign lane    = 32'(rdata >> bit_off);

  // Store side: byte enables by access size, data moved up to its lane
  always_comb begin
    lane_wmask = '0;
    if (save_info[SAVE_SB])
      lane_wmask = 8'h01 << addr_lo;
    else if (save_info[SAVE_SH])
      lane_wmask = 8'h03 << addr_lo;
    else if (save_info[SAVE_SW])
      lane_wmask = 8'h0F << addr_lo;
    else if (save_info[SAVE_SD])
      lane_wmask = 8'hFF;
    lane_wdata = (|save_info) ? (wdata << bit_off) : '0;
  end

  // Load side: select the addressed lane, then sign- or zero-extend
  always_comb begin
    load_data = '0;
    if (load_info[LOAD_LB])
      load_data = {{56{lane[7]}}, lane[7:0]};
    else if (load_info[LOAD_LH])
      load_data = {{48{lane[15]}}, lane[15:0]};
    else if (load_info[LOAD_LW])
      load_data = {{32{lane[31]}}, lane[31:0]};
    else if (load_info[LOAD_LD])
      load_data = rdata;
    else if (load_info[LOAD_LBU])
      load_data = {56'b0, lane[7:0]};
    else if (load_info[LOAD_LHU])
      load_data = {48'b0, lane[15:0]};
    else if (load_info[LOAD_LWU])
      load_data = {32'b0, lane[31:0]};
  end

endmodule

// File: rtl/mem_ctrl.sv
// Load/store sequencer between execute and the data-memory bus.
// Accepts one operation in IDLE, runs a request/response handshake, stalls
// upstream until done, then returns extended load data or a fault.
// Optional feature: define MEM_CTRL_TIMEOUT_EN to abandon a WAIT after
// TIMEOUT_CYCLES cycles without a response (reported as a fault).
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_rd_ena,
  input  logic                 mem_wr_ena,
  input  logic [LOAD_W-1:0]    load_info,
  input  logic [SAVE_W-1:0]    save_info,
  input  logic [XLEN-1:0]      mem_addr,
  input  logic [XLEN-1:0]      mem_wdata,
  input  logic [REG_W-1:0]     rd_addr,
  output logic                 stall,
  output logic                 bus_req_valid,
  input  logic                 bus_req_ready,
  output logic                 bus_we,
  output logic [XLEN-1:0]      bus_addr,
  output logic [XLEN-1:0]      bus_wdata,
  output logic [BUS_BYTES-1:0] bus_wmask,
  input  logic                 bus_resp_valid,
  input  logic [XLEN-1:0]      bus_rdata,
  output logic                 done,
  output logic                 wb_ena,
  output logic [REG_W-1:0]     wb_addr,
  output logic [XLEN-1:0]      wb_data,
  output logic                 fault
);

  mem_state_t state;
  mem_state_t state_next;

  logic request;
  logic misaligned_in;
  logic timeout_hit;

  logic              is_load_r;
  logic              fault_r;
  logic [LOAD_W-1:0] load_info_r;
  logic [SAVE_W-1:0] save_info_r;
  logic [XLEN-1:0]   addr_r;
  logic [XLEN-1:0]   wdata_r;
  logic [XLEN-1:0]   rdata_r;
  logic [REG_W-1:0]  rd_r;

  logic [XLEN-1:0]      lane_wdata;
  logic [BUS_BYTES-1:0] lane_wmask;
  logic [XLEN-1:0]      load_data;

  // While reset is held no request is seen, so stall cannot leak out
  assign request       = rst & (mem_rd_ena | mem_wr_ena);
  assign misaligned_in = is_misaligned(mem_rd_ena, load_info, save_info, mem_addr[2:0]);

`ifdef MEM_CTRL_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;

  // Count WAIT cycles; held at zero while the request is still outstanding
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wait_cnt <= '0;
    else if (state == MEM_ST_REQ)
      wait_cnt <= '0;
    else if (state == MEM_ST_WAIT)
      wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign timeout_hit = (state == MEM_ST_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Without the counter WAIT never gives up; this is constant false
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= MEM_ST_IDLE;
    else
      state <= state_next;
  end

  // Next-state logic: misaligned accesses skip the bus entirely
  always_comb begin
    state_next = state;
    case (state)
      MEM_ST_IDLE: if (request) state_next = misaligned_in ? MEM_ST_DONE : MEM_ST_REQ;
      MEM_ST_REQ:  if (bus_req_ready) state_next = MEM_ST_WAIT;
      MEM_ST_WAIT: if (bus_resp_valid || timeout_hit) state_next = MEM_ST_DONE;
      MEM_ST_DONE: state_next = MEM_ST_IDLE;
      default:     state_next = MEM_ST_IDLE;
    endcase
  end

  // Capture the operation on acceptance and the read data on response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_load_r   <= 1'b0;
      fault_r     <= 1'b0;
      load_info_r <= '0;
      save_info_r <= '0;
      addr_r      <= '0;
      wdata_r     <= '0;
      rdata_r     <= '0;
      rd_r        <= '0;
    end else if (state == MEM_ST_IDLE && request) begin
      is_load_r   <= mem_rd_ena;
      fault_r     <= misaligned_in;
      load_info_r <= mem_rd_ena ? load_info : '0;
      save_info_r <= mem_rd_ena ? '0 : save_info;
      addr_r      <= mem_addr;
      wdata_r     <= mem_wdata;
      rdata_r     <= '0;
      rd_r        <= rd_addr;
    end else if (state == MEM_ST_WAIT) begin
      if (bus_resp_valid)
        rdata_r <= bus_rdata;
      else if (timeout_hit)
        fault_r <= 1'b1;
    end
  end

  mem_data_align u_align (
    .save_info  (save_info_r),
    .load_info  (load_info_r),
    .addr_lo    (addr_r[2:0]),
    .wdata      (wdata_r),
    .rdata      (rdata_r),
    .lane_wdata (lane_wdata),
    .lane_wmask (lane_wmask),
    .load_data  (load_data)
  );

  // Output decode: bus fields only in REQ, write-back only on done
  always_comb begin
    stall         = 1'b0;
    bus_req_valid = 1'b0;
    bus_we        = 1'b0;
    bus_addr      = '0;
    bus_wdata     = '0;
    bus_wmask     = '0;
    done          = 1'b0;
    wb_ena        = 1'b0;
    wb_addr       = '0;
    wb_data       = '0;
    fault         = 1'b0;
    case (state)
      MEM_ST_IDLE: stall = request;
      MEM_ST_REQ: begin
        stall         = 1'b1;
        bus_req_valid = 1'b1;
        bus_we        = ~is_load_r;
        bus_addr      = {addr_r[XLEN-1:3], 3'b000};
        bus_wdata     = lane_wdata;
        bus_wmask     = lane_wmask;
      end
      MEM_ST_WAIT: stall = 1'b1;
      MEM_ST_DONE: begin
        done  = 1'b1;
        fault = fault_r;
        if (is_load_r) begin
          wb_addr = rd_r;
          wb_ena  = (rd_r != '0) & ~fault_r;
          wb_data = fault_r ? '0 : load_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed cases with literal results,
// then randomized loads/stores against a byte-level reference model.
module tb_mem_ctrl;

`ifdef MEM_CTRL_TIMEOUT_EN
  localparam int TMO    = 4;
  localparam int RMAX   = 2;
  localparam int LONG_R = 2;
`else
  localparam int TMO    = 4;
  localparam int RMAX   = 6;
  localparam int LONG_R = 4;
`endif

  logic        clk;
  logic        rst;
  logic        mem_rd_ena;
  logic        mem_wr_ena;
  logic [6:0]  load_info;
  logic [3:0]  save_info;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [4:0]  rd_addr;
  logic        stall;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wmask;
  logic        bus_resp_valid;
  logic [63:0] bus_rdata;
  logic        done;
  logic        wb_ena;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        fault;

  mem_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_rd_ena     (mem_rd_ena),
    .mem_wr_ena     (mem_wr_ena),
    .load_info      (load_info),
    .save_info      (save_info),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .rd_addr        (rd_addr),
    .stall          (stall),
    .bus_req_valid  (bus_req_valid),
    .bus_req_ready  (bus_req_ready),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_wmask      (bus_wmask),
    .bus_resp_valid (bus_resp_valid),
    .bus_rdata      (bus_rdata),
    .done           (done),
    .wb_ena         (wb_ena),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Current operation and its expected schedule (cycles since acceptance)
  bit          active = 0;
  int          cyc = 0;
  int          exp_lat = 0;
  int          rdy_cyc = 0;
  int          resp_cyc = -1;
  bit          m_load = 0;
  bit          m_mis = 0;
  bit          m_noresp = 0;
  int          m_kind = 0;
  logic [63:0] m_addr = '0;
  logic [63:0] m_wdata = '0;
  logic [63:0] m_rdata = '0;
  logic [4:0]  m_rd = '0;

  // Values observed on the last request/done cycle, for literal checks
  logic [63:0] last_bus_addr = '0;
  logic [63:0] last_bus_wdata = '0;
  logic [7:0]  last_wmask = '0;
  logic [63:0] last_wb_data = '0;
  logic [4:0]  last_wb_addr = '0;
  logic        last_wb_ena = 0;
  logic        last_fault = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int load_size(input int k);
    case (k)
      0, 4:    return 1;
      1, 5:    return 2;
      2, 6:    return 4;
      default: return 8;
    endcase
  endfunction

  // Gather bytes little-endian from the addressed offset, then extend
  function automatic logic [63:0] model_load(input int k, input logic [2:0] a, input logic [63:0] raw);
    logic [63:0] v;
    int sz;
    int idx;
    sz = load_size(k);
    v = '0;
    for (int i = 0; i < sz; i++) begin
      idx = int'(a) + i;
      if (idx < 8) v[8*i +: 8] = raw[8*idx +: 8];
    end
    if (k <= 2 && v[8*sz-1])
      for (int i = sz; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] model_mask(input int sz, input logic [2:0] a);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < sz; i++)
      if (int'(a) + i < 8) m[int'(a) + i] = 1'b1;
    return m;
  endfunction

  // Compare every cycle against the schedule and the byte-level model
  always @(negedge clk) begin
    bit e_stall;
    bit e_rv;
    bit e_done;
    bit e_fault;
    e_stall = active && (cyc < exp_lat);
    e_rv    = active && !m_mis && (cyc >= 1) && (cyc <= rdy_cyc);
    e_done  = active && (cyc == exp_lat);
    checkOutput("stall", 64'(stall), 64'(e_stall));
    checkOutput("bus_req_valid", 64'(bus_req_valid), 64'(e_rv));
    checkOutput("done", 64'(done), 64'(e_done));
    if (e_rv) begin
      checkOutput("bus_we", 64'(bus_we), 64'(!m_load));
      checkOutput("bus_addr", bus_addr, {m_addr[63:3], 3'b000});
      checkOutput("bus_wmask", 64'(bus_wmask),
                  m_load ? 64'd0 : 64'(model_mask(1 << m_kind, m_addr[2:0])));
      checkOutput("bus_wdata", bus_wdata,
                  m_load ? 64'd0 : (m_wdata << (8 * int'(m_addr[2:0]))));
      last_bus_addr  = bus_addr;
      last_bus_wdata = bus_wdata;
      last_wmask     = bus_wmask;
    end
    if (e_done) begin
      e_fault = m_mis || m_noresp;
      checkOutput("fault", 64'(fault), 64'(e_fault));
      checkOutput("wb_ena", 64'(wb_ena), 64'(m_load && (m_rd != 0) && !e_fault));
      checkOutput("wb_addr", 64'(wb_addr), m_load ? 64'(m_rd) : 64'd0);
      checkOutput("wb_data", wb_data,
                  (m_load && !e_fault) ? model_load(m_kind, m_addr[2:0], m_rdata) : 64'd0);
      last_wb_data = wb_data;
      last_wb_addr = wb_addr;
      last_wb_ena  = wb_ena;
      last_fault   = fault;
    end else begin
      checkOutput("idle_wb_ena", 64'(wb_ena), 64'd0);
    end
  end

  // Bus responder for the current cycle: ready/response exactly on schedule,
  // random noise (with garbage data) wherever the DUT must ignore it
  task automatic driveBus();
    bit in_req;
    bit in_wait;
    in_req  = !m_mis && (cyc >= 1) && (cyc <= rdy_cyc);
    in_wait = !m_mis && (cyc > rdy_cyc) && (cyc < exp_lat);
    if (in_req) bus_req_ready = (cyc == rdy_cyc);
    else        bus_req_ready = 1'($urandom % 2);
    if (in_wait) begin
      bus_resp_valid = (cyc == resp_cyc);
      bus_rdata      = (cyc == resp_cyc) ? m_rdata : {$urandom, $urandom};
    end else begin
      bus_resp_valid = 1'($urandom % 2);
      bus_rdata      = {$urandom, $urandom};
    end
  endtask

  task automatic applyStimulus(input bit ld, input int kind, input logic [63:0] addr,
                               input logic [63:0] wd, input logic [63:0] raw, input logic [4:0] rd,
                               input int d, input int r, input bit noresp, input int abort_at);
    int sz;
    sz       = ld ? load_size(kind) : (1 << kind);
    m_load   = ld;
    m_kind   = kind;
    m_addr   = addr;
    m_wdata  = wd;
    m_rdata  = raw;
    m_rd     = rd;
    m_noresp = noresp;
    m_mis    = (int'(addr[2:0]) % sz) != 0;
    rdy_cyc  = 1 + d;
    if (m_mis)       exp_lat = 1;
    else if (noresp) exp_lat = 2 + d + TMO;
    else             exp_lat = 3 + d + r;
    resp_cyc   = noresp ? -1 : 2 + d + r;
    mem_rd_ena = ld;
    mem_wr_ena = ld ? 1'($urandom % 2) : 1'b1;
    load_info  = ld ? 7'(1 << kind) : 7'($urandom);
    save_info  = ld ? 4'(1 << ($urandom % 4)) : 4'(1 << kind);
    mem_addr   = addr;
    mem_wdata  = wd;
    rd_addr    = rd;
    cyc        = 0;
    active     = 1;
    while (active) begin
      driveBus();
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == abort_at) begin
        rst    = 1'b0;
        active = 0;
        #1;
        checkOutput("abort_req_valid", 64'(bus_req_valid), 64'd0);
        checkOutput("abort_stall", 64'(stall), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
      end else if (cyc > exp_lat) begin
        active         = 0;
        mem_rd_ena     = 0;
        mem_wr_ena     = 0;
        bus_req_ready  = 0;
        bus_resp_valid = 0;
      end
    end
  endtask

  initial begin
    clk = 0;
    rst = 0;
    mem_rd_ena = 0;
    mem_wr_ena = 0;
    load_info = '0;
    save_info = '0;
    mem_addr = '0;
    mem_wdata = '0;
    rd_addr = '0;
    bus_req_ready = 0;
    bus_resp_valid = 0;
    bus_rdata = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_bus_addr", bus_addr, 64'd0);
    checkOutput("reset_wb_data", wb_data, 64'd0);
    checkOutput("reset_fault", 64'(fault), 64'd0);
    rst = 1;
    @(posedge clk);
    #1;

    // LD, immediate handshake
    applyStimulus(1, 3, 64'h1000, 64'd0, 64'h1122334455667788, 5'd5, 0, 0, 0, -1);
    checkOutput("ld_wb_data", last_wb_data, 64'h1122334455667788);
    checkOutput("ld_wb_addr", 64'(last_wb_addr), 64'd5);

    // LB / LBU on the same lane
    applyStimulus(1, 0, 64'h1003, 64'd0, 64'h0000000080000000, 5'd9, 0, 0, 0, -1);
    checkOutput("lb_wb_data", last_wb_data, 64'hFFFFFFFFFFFFFF80);
    applyStimulus(1, 4, 64'h1003, 64'd0, 64'h0000000080000000, 5'd9, 0, 0, 0, -1);
    checkOutput("lbu_wb_data", last_wb_data, 64'h80);

    // SH into the top half-word
    applyStimulus(0, 1, 64'h2006, 64'hBEEF, 64'd0, 5'd3, 0, 0, 0, -1);
    checkOutput("sh_wmask", 64'(last_wmask), 64'hC0);
    checkOutput("sh_wdata", last_bus_wdata, 64'hBEEF000000000000);
    checkOutput("sh_addr", last_bus_addr, 64'h2000);
    checkOutput("sh_wb_ena", 64'(last_wb_ena), 64'd0);

    // Misaligned LW
    applyStimulus(1, 2, 64'h3002, 64'd0, 64'd0, 5'd4, 0, 0, 0, -1);
    checkOutput("lw_mis_fault", 64'(last_fault), 64'd1);

    // Slow bus: ready withheld 5 cycles, response later
    applyStimulus(1, 2, 64'h3004, 64'd0, 64'hDEADBEEF_7000_0001, 5'd6, 5, LONG_R, 0, -1);
    checkOutput("slow_lw_data", last_wb_data, 64'hFFFFFFFFDEADBEEF);

    // Reset in WAIT with the request still held, then a late response
    applyStimulus(1, 3, 64'h4000, 64'd0, 64'h55, 5'd7, 0, 6, 0, 3);
    repeat (2) @(posedge clk);
    #1;
    mem_rd_ena = 0;
    mem_wr_ena = 0;
    rst = 1;
    bus_resp_valid = 1;
    bus_rdata = 64'h1234;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("late_resp_done", 64'(done), 64'd0);
    bus_resp_valid = 0;

`ifdef MEM_CTRL_TIMEOUT_EN
    applyStimulus(1, 3, 64'h5000, 64'd0, 64'd0, 5'd8, 0, 0, 1, -1);
    checkOutput("timeout_fault", 64'(last_fault), 64'd1);
`endif

    // Randomized operations
    for (int n = 0; n < 300; n++) begin
      bit          ld;
      int          kind;
      int          sz;
      logic [63:0] addr;
      ld   = 1'($urandom % 2);
      kind = ld ? int'($urandom % 7) : int'($urandom % 4);
      sz   = ld ? load_size(kind) : (1 << kind);
      addr = {$urandom, $urandom};
      if ($urandom % 3 != 0) addr = addr & ~64'(sz - 1);
      applyStimulus(ld, kind, addr, {$urandom, $urandom}, {$urandom, $urandom},
                    5'($urandom % 32), int'($urandom % 4), int'($urandom_range(0, RMAX)), 0, -1);
      if ($urandom % 2 == 1) begin
        @(posedge clk);
        #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
